// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Round-robin arbiter that shares one single-port synchronous RAM between three
// requesters: instruction fetch (0), operand-stack spill/fill (1) and
// linear-memory load/store (2). One transaction is in flight at a time.
// Addresses at or above MEM_WORDS are answered with an error response and no
// memory access.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   req_valid    per-requester request (bit i = requester i)
//   req_we       per-requester write enable
//   req_addr     packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata    packed write data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready    one-hot accept (combinational, only in IDLE)
//   resp_valid   one-hot, one-cycle response pulse
//   resp_rdata   read data (0 for writes and errors), valid with resp_valid
//   resp_err     out-of-range flag, valid with resp_valid
//   mem_en       memory strobe (one cycle per access)
//   mem_we       memory write enable
//   mem_addr     memory address (holds last value)
//   mem_wdata    memory write data (holds last value)
//   mem_rdata    memory read data, valid MEM_LATENCY cycles after mem_en
//   busy         high whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 64,
  parameter int MEM_WORDS   = 65536,
  parameter int MEM_LATENCY = 1      // legal range 1..4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2:0]              req_valid,
  input  logic [2:0]              req_we,
  input  logic [3*ADDR_WIDTH-1:0] req_addr,
  input  logic [3*DATA_WIDTH-1:0] req_wdata,
  output logic [2:0]              req_ready,
  output logic [2:0]              resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_ERR
  } state_t;

  // Range limit one bit wider than the address so MEM_WORDS == 2**ADDR_WIDTH
  // (every address valid) is representable.
  localparam logic [ADDR_WIDTH:0] LP_LIMIT =
    (MEM_WORDS >= (2 ** ADDR_WIDTH)) ? {1'b1, {ADDR_WIDTH{1'b0}}}
                                     : (ADDR_WIDTH + 1)'(MEM_WORDS);

  state_t                  r_state;
  state_t                  w_next_state;
  logic [1:0]              r_ptr;
  logic [1:0]              r_id;
  logic                    r_we;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [2:0]              r_cnt;

  logic [2:0]              w_pick;
  logic [1:0]              w_grant;
  logic                    w_accept;
  logic [ADDR_WIDTH-1:0]   w_win_addr;
  logic                    w_in_range;

  // Round-robin search: ptr has the highest priority, then ptr+1, ptr+2 mod 3.
  // Iterating from the lowest priority up lets the highest-priority hit win.
  function automatic logic [2:0] rr_pick(input logic [2:0] valid,
                                         input logic [1:0] ptr);
    logic [2:0] pick;
    logic [1:0] idx;
    pick = '0;
    for (int off = 2; off >= 0; off--) begin
      idx = 2'((32'(ptr) + off) % 3);
      if (valid[idx]) pick = 3'b001 << idx;
    end
    return pick;
  endfunction

  assign w_pick     = rr_pick(req_valid, r_ptr);
  assign w_grant    = w_pick[2] ? 2'd2 : (w_pick[1] ? 2'd1 : 2'd0);
  // Gating with reset keeps req_ready at zero while reset is held.
  assign w_accept   = reset && (r_state == ST_IDLE) && (|req_valid);
  assign w_win_addr = req_addr[w_grant*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_in_range = ({1'b0, w_win_addr} < LP_LIMIT);

  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    req_ready    = 3'b000;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    busy         = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (w_accept) begin
          req_ready    = w_pick;
          w_next_state = w_in_range ? ST_ISSUE : ST_ERR;
        end
      end
      ST_ISSUE: begin
        mem_en       = 1'b1;
        mem_we       = r_we;
        w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        // The counter reads 1 in the cycle mem_rdata is valid.
        if (r_cnt == 3'd1) w_next_state = ST_IDLE;
      end
      ST_ERR: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr      <= 2'd0;
      r_id       <= 2'd0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cnt      <= 3'd0;
      resp_valid <= 3'b000;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      // Response outputs are single-cycle pulses.
      resp_valid <= 3'b000;
      resp_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_id    <= w_grant;
            r_we    <= req_we[w_grant];
            r_addr  <= w_win_addr;
            r_wdata <= req_wdata[w_grant*DATA_WIDTH +: DATA_WIDTH];
            r_ptr   <= (w_grant == 2'd2) ? 2'd0 : w_grant + 2'd1;
          end
        end
        ST_ISSUE: begin
          r_cnt <= 3'(MEM_LATENCY);
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd1) begin
            resp_valid <= 3'b001 << r_id;
            resp_rdata <= r_we ? '0 : mem_rdata;
          end
        end
        ST_ERR: begin
          resp_valid <= 3'b001 << r_id;
          resp_err   <= 1'b1;
          resp_rdata <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Scoreboard bench for mem_arbiter. A transaction-level reference model runs
// at the falling edge: it predicts which requester the upcoming rising edge
// accepts (round-robin over a pointer), applies the access to a model memory
// and pushes the expected response with the cycle it is due. A monitor in the
// same sampling slot pops the queue whenever the DUT presents a response.
// A behavioural RAM with MEM_LATENCY read latency serves the DUT.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int AW  = 8;
  localparam int DW  = 64;
  localparam int MW  = 200;
  localparam int LAT = 3;

  logic            clk;
  logic            rst;
  logic [2:0]      req_valid;
  logic [2:0]      req_we;
  logic [3*AW-1:0] req_addr;
  logic [3*DW-1:0] req_wdata;
  logic [2:0]      req_ready;
  logic [2:0]      resp_valid;
  logic [DW-1:0]   resp_rdata;
  logic            resp_err;
  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic            busy;

  mem_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MEM_WORDS  (MW),
    .MEM_LATENCY(LAT)
  ) dut (
    .clk       (clk),
    .reset     (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural RAM ----------------
  logic [DW-1:0] ram    [MW];
  logic [DW-1:0] rd_pipe[LAT];

  always @(posedge clk) begin
    if (mem_en && mem_we && (32'(mem_addr) < MW)) ram[mem_addr] <= mem_wdata;
    rd_pipe[0] <= (mem_en && !mem_we && (32'(mem_addr) < MW)) ? ram[mem_addr] : '0;
    for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int            id;
    logic [DW-1:0] rdata;
    logic          err;
    int            due;
  } exp_t;

  exp_t          sb_q[$];
  logic [DW-1:0] model_mem[MW];
  int            cyc       = 0;
  int            m_ptr     = 0;
  int            free_at   = 0;
  int            en_cyc    = -1;
  logic          en_we;
  logic [AW-1:0] en_addr;
  logic [DW-1:0] en_wdata;
  int            m_win;
  logic [2:0]    exp_ready;
  logic [AW-1:0] m_addr;
  exp_t          e;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      check("rst_req_ready",  64'(req_ready),  64'd0);
      check("rst_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_resp_rdata", resp_rdata,      64'd0);
      check("rst_resp_err",   64'(resp_err),   64'd0);
      check("rst_mem_en",     64'(mem_en),     64'd0);
      check("rst_mem_we",     64'(mem_we),     64'd0);
      check("rst_mem_addr",   64'(mem_addr),   64'd0);
      check("rst_mem_wdata",  mem_wdata,       64'd0);
      check("rst_busy",       64'(busy),       64'd0);
      sb_q.delete();
      m_ptr   = 0;
      free_at = 0;
      en_cyc  = -1;
    end else begin
      // response monitor
      if (resp_valid != 3'b000) begin
        if (sb_q.size() == 0) begin
          check("unexpected_resp", 64'(resp_valid), 64'd0);
        end else begin
          e = sb_q.pop_front();
          check("resp_valid", 64'(resp_valid), 64'(3'b001 << e.id));
          check("resp_cycle", 64'(cyc), 64'(e.due));
          check("resp_err",   64'(resp_err), 64'(e.err));
          check("resp_rdata", resp_rdata, e.rdata);
        end
      end else if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
        e = sb_q.pop_front();
        check("missing_resp", 64'(resp_valid), 64'(3'b001 << e.id));
      end

      // busy: every cycle between an accept and its response cycle
      check("busy", 64'(busy), 64'(cyc < free_at));

      // memory strobe exactly one cycle after a valid accept
      check("mem_en", 64'(mem_en), 64'(cyc == en_cyc));
      check("mem_we", 64'(mem_we), 64'((cyc == en_cyc) && en_we));
      if (cyc == en_cyc) begin
        check("mem_addr", 64'(mem_addr), 64'(en_addr));
        if (en_we) check("mem_wdata", mem_wdata, en_wdata);
      end

      // arbitration prediction for the upcoming edge
      exp_ready = 3'b000;
      if (cyc >= free_at && req_valid != 3'b000) begin
        m_win = -1;
        for (int off = 0; off < 3; off++) begin
          if (m_win < 0 && req_valid[(m_ptr + off) % 3]) m_win = (m_ptr + off) % 3;
        end
        exp_ready = 3'b001 << m_win;
        m_addr    = req_addr[m_win*AW +: AW];
        e.id      = m_win;
        if (32'(m_addr) >= MW) begin
          e.rdata = '0;
          e.err   = 1'b1;
          e.due   = cyc + 2;
          free_at = cyc + 2;
        end else begin
          if (req_we[m_win]) begin
            model_mem[m_addr] = req_wdata[m_win*DW +: DW];
            e.rdata = '0;
          end else begin
            e.rdata = model_mem[m_addr];
          end
          e.err    = 1'b0;
          e.due    = cyc + 2 + LAT;
          free_at  = cyc + 2 + LAT;
          en_cyc   = cyc + 1;
          en_we    = req_we[m_win];
          en_addr  = m_addr;
          en_wdata = req_wdata[m_win*DW +: DW];
        end
        sb_q.push_back(e);
        m_ptr = (m_win + 1) % 3;
      end
      check("req_ready", 64'(req_ready), 64'(exp_ready));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]           = v;
    req_we[i]              = we;
    req_addr[i*AW +: AW]   = a;
    req_wdata[i*DW +: DW]  = d;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < 3; i++) set_req(i, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    for (int i = 0; i < MW; i++) begin
      ram[i]       = {$urandom, $urandom};
      model_mem[i] = ram[i];
    end
    ram[5]       = 64'hDEAD;
    model_mem[5] = 64'hDEAD;
    for (int k = 0; k < LAT; k++) rd_pipe[k] = '0;

    rst = 1'b0;
    clear_reqs();
    // all three requesters valid while and after reset
    set_req(0, 1'b1, 1'b0, 8'd1, '0);
    set_req(1, 1'b1, 1'b0, 8'd2, '0);
    set_req(2, 1'b1, 1'b0, 8'd3, '0);
    step(3);
    rst = 1'b1;
    step(3 * (LAT + 2) - LAT - 1);
    clear_reqs();
    step(LAT + 3);

    // single read of RAM[5]
    set_req(0, 1'b1, 1'b0, 8'd5, '0);
    step(1);
    clear_reqs();
    step(LAT + 3);

    // requesters 0 and 2 held valid continuously
    set_req(0, 1'b1, 1'b0, 8'd10, '0);
    set_req(2, 1'b1, 1'b0, 8'd11, '0);
    step(4 * (LAT + 2));
    clear_reqs();
    step(LAT + 3);

    // write then read-back through a different requester
    set_req(2, 1'b1, 1'b1, 8'd7, 64'h1234);
    step(1);
    clear_reqs();
    step(LAT + 2);
    set_req(1, 1'b1, 1'b0, 8'd7, '0);
    step(1);
    clear_reqs();
    step(LAT + 3);

    // out-of-range read and the last in-range address
    set_req(1, 1'b1, 1'b0, 8'd220, '0);
    step(1);
    clear_reqs();
    step(3);
    set_req(2, 1'b1, 1'b0, 8'(MW - 1), '0);
    step(1);
    clear_reqs();
    step(LAT + 3);

    // reset during WAIT abandons the transaction
    set_req(1, 1'b1, 1'b0, 8'd3, '0);
    step(1);
    clear_reqs();
    step(2);
    rst = 1'b0;
    #1;
    check("midrst_resp_valid", 64'(resp_valid), 64'd0);
    check("midrst_mem_en",     64'(mem_en),     64'd0);
    check("midrst_busy",       64'(busy),       64'd0);
    check("midrst_req_ready",  64'(req_ready),  64'd0);
    check("midrst_resp_err",   64'(resp_err),   64'd0);
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, 1'b0, 8'(20 + i), '0);
    step(2);
    rst = 1'b1;
    step(2 * (LAT + 2) + 1);
    clear_reqs();
    step(LAT + 3);

    // randomized traffic
    repeat (600) begin
      for (int i = 0; i < 3; i++)
        set_req(i, 1'($urandom), 1'($urandom), 8'($urandom_range(0, 255)),
                {$urandom, $urandom});
      step(1);
    end
    clear_reqs();

    // drain with a bounded wait
    for (int t = 0; t < 20 && sb_q.size() != 0; t++) step(1);
    check("drain_queue_empty", 64'(sb_q.size()), 64'd0);
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
